// File: rtl/count_mod_ud.sv
// count_mod_ud
// ------------
// This is a modulo-MOD up/down counter with an optional prescaler.
// The count X advances once every DIV enabled cycles, which is when Tick is
// high. Direction is chosen each cycle by Up. When SAT=0, X wraps at the
// terminal value. When SAT=1, X holds at the terminal value.
//
// The counter is N bits wide and counts modulo the given modulus, so X always
// stays between zero and one below the modulus. With a prescale ratio of one
// there is no prescaler register at all. The saturation flag chooses between
// wrapping and holding at the terminal value.
//
// Reset is asynchronous and clears both the count and the prescaler. Clear is
// a synchronous clear with the highest priority. Load copies D into the count,
// clamped to the top value, and also restarts the prescaler. Enable advances
// the prescaler. Up selects the counting direction. AtEnd shows that the count
// is at the terminal value for the current direction. Carry is Tick AND AtEnd
// and is meant to drive the Enable of the next cascaded stage.

module count_mod_ud #(
  parameter int N   = 4,
  parameter int MOD = 16,
  parameter int DIV = 1,
  parameter int SAT = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Enable,
  input  logic         Clear,
  input  logic         Load,
  input  logic [N-1:0] D,
  input  logic         Up,
  output logic [N-1:0] X,
  output logic         AtEnd,
  output logic         Carry
);

  localparam logic [N-1:0] TERM  = N'(MOD - 1);
  localparam logic [31:0]  MOD_W = 32'(MOD);

  logic [N-1:0] x_q, x_d;
  logic         tick;
  logic         d_in_range;

  // The comparison is done at 32 bits so that MOD = 2^N (e.g. 65536 when
  // N=16) is still representable.
  assign d_in_range = ({{(32-N){1'b0}}, D} < MOD_W);

  generate
    if (DIV == 1) begin : g_no_prescale
      assign tick = Enable;
    end else begin : g_prescale
      localparam int PW = $clog2(DIV);
      localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

      logic [PW-1:0] p_q, p_d;

      // Clear and Load both restart the prescaler phase. Otherwise the
      // prescaler runs only while Enable is high.
      always_comb begin
        p_d = p_q;
        if (Clear || Load) begin
          p_d = '0;
        end else if (Enable) begin
          p_d = (p_q == P_LAST) ? '0 : p_q + PW'(1);
        end
      end

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          p_q <= '0;
        end else begin
          p_q <= p_d;
        end
      end

      assign tick = Enable && (p_q == P_LAST);
    end
  endgenerate

  // Priority order: Clear, then Load, then Tick, otherwise hold. In SAT mode
  // the terminal value is held, but Carry still fires on every Tick there.
  always_comb begin
    x_d = x_q;
    if (Clear) begin
      x_d = '0;
    end else if (Load) begin
      x_d = d_in_range ? D : TERM;
    end else if (tick) begin
      if (Up) begin
        if (x_q == TERM) begin
          x_d = (SAT != 0) ? TERM : '0;
        end else begin
          x_d = x_q + N'(1);
        end
      end else begin
        if (x_q == '0) begin
          x_d = (SAT != 0) ? '0 : TERM;
        end else begin
          x_d = x_q - N'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q <= '0;
    end else begin
      x_q <= x_d;
    end
  end

  assign X     = x_q;
  assign AtEnd = Up ? (x_q == TERM) : (x_q == '0);
  assign Carry = tick && AtEnd;

endmodule

// File: tb/tb_count_mod_ud.sv
// tb_count_mod_ud
// ---------------
// Directed bench for count_mod_ud. It uses several instances:
//   uA : N=4 MOD=10 DIV=1 SAT=0  (main vector table, lower cascade stage)
//   uB : N=4 MOD=10 DIV=1 SAT=0  (upper cascade stage, Enable = carryA)
//   uC : N=4 MOD=10 DIV=3 SAT=0  (prescaler and asynchronous reset)
//   uD : N=4 MOD=10 DIV=1 SAT=1  (saturating down count)
//   uE : N=4 MOD=16 DIV=1 SAT=0  (natural 4-bit rollover)
// Clock, reset, Clear, Load, D and Up are shared by all instances. Each
// instance has its own Enable.

module tb_count_mod_ud;

  typedef struct {
    bit       clr;
    bit       ld;
    bit       en;
    bit       up;
    bit [3:0] d;
    bit       expAtEnd;
    bit       expCarry;
    bit [3:0] expX;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       load  = 1'b0;
  logic [3:0] d     = '0;
  logic       up    = 1'b1;
  logic       enA = 1'b0, enC = 1'b0, enD = 1'b0, enE = 1'b0;

  logic [3:0] xA, xB, xC, xD, xE;
  logic       atEndA, atEndB, atEndC, atEndD, atEndE;
  logic       carryA, carryB, carryC, carryD, carryE;

  int checkCount = 0;
  int errorCount = 0;

  vec_t vecs[$];

  always #5 clock = ~clock;

  count_mod_ud #(.N(4), .MOD(10), .DIV(1), .SAT(0)) uA (
    .Clk(clock), .Reset(reset), .Enable(enA), .Clear(clear), .Load(load),
    .D(d), .Up(up), .X(xA), .AtEnd(atEndA), .Carry(carryA));

  count_mod_ud #(.N(4), .MOD(10), .DIV(1), .SAT(0)) uB (
    .Clk(clock), .Reset(reset), .Enable(carryA), .Clear(clear), .Load(load),
    .D(d), .Up(up), .X(xB), .AtEnd(atEndB), .Carry(carryB));

  count_mod_ud #(.N(4), .MOD(10), .DIV(3), .SAT(0)) uC (
    .Clk(clock), .Reset(reset), .Enable(enC), .Clear(clear), .Load(load),
    .D(d), .Up(up), .X(xC), .AtEnd(atEndC), .Carry(carryC));

  count_mod_ud #(.N(4), .MOD(10), .DIV(1), .SAT(1)) uD (
    .Clk(clock), .Reset(reset), .Enable(enD), .Clear(clear), .Load(load),
    .D(d), .Up(up), .X(xD), .AtEnd(atEndD), .Carry(carryD));

  count_mod_ud #(.N(4), .MOD(16), .DIV(1), .SAT(0)) uE (
    .Clk(clock), .Reset(reset), .Enable(enE), .Clear(clear), .Load(load),
    .D(d), .Up(up), .X(xE), .AtEnd(atEndE), .Carry(carryE));

  // One comparison: count it, and report it only if it fails.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one table record on the falling edge, away from the active edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    clear = v.clr;
    load  = v.ld;
    enA   = v.en;
    up    = v.up;
    d     = v.d;
  endtask

  function automatic void addVec(input bit clr, input bit ld, input bit en, input bit u,
                                 input bit [3:0] dv, input bit ae, input bit cy, input bit [3:0] x);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.up = u; v.d = dv;
    v.expAtEnd = ae; v.expCarry = cy; v.expX = x;
    vecs.push_back(v);
  endfunction

  // Hold reset for one edge with all inputs quiet, then release on a falling edge.
  task automatic resetAll();
    reset = 1'b1;
    clear = 1'b0; load = 1'b0; d = '0; up = 1'b1;
    enA = 1'b0; enC = 1'b0; enD = 1'b0; enE = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int expC[7];
    int expPre[4];
    int expPost[4];

    // ---- Reset holds X at 0 and ignores inputs; AtEnd follows Up ----
    reset = 1'b1; load = 1'b1; d = 4'd5; enA = 1'b1; up = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_x", 32'(xA), 32'd0);
    checkOutput("reset_atend_down", 32'(atEndA), 32'd1);
    up = 1'b1;
    #1;
    checkOutput("reset_atend_up", 32'(atEndA), 32'd0);

    // ---- Table: MOD=10 count, direction change, priority, load clamp ----
    for (int i = 0; i < 10; i++)
      addVec(0, 0, 1, 1, 4'd0, (i == 9), (i == 9), (i == 9) ? 4'd0 : 4'(i + 1));
    addVec(0, 0, 1, 0, 4'd0,  1, 1, 4'd9);   // down from 0 wraps to 9
    addVec(0, 0, 1, 0, 4'd0,  0, 0, 4'd8);
    addVec(0, 0, 0, 1, 4'd0,  0, 0, 4'd8);   // no enable: hold
    addVec(0, 1, 0, 1, 4'd5,  0, 0, 4'd5);   // load 5
    addVec(1, 1, 1, 1, 4'd7,  0, 0, 4'd0);   // clear beats load and tick
    addVec(0, 1, 1, 1, 4'd7,  0, 0, 4'd7);   // load beats tick
    addVec(0, 1, 0, 1, 4'd12, 0, 0, 4'd9);   // out of range load clamps to 9
    addVec(0, 0, 0, 1, 4'd0,  1, 0, 4'd9);   // at end, no tick, no carry
    addVec(0, 0, 0, 0, 4'd0,  0, 0, 4'd9);   // AtEnd follows Up
    addVec(0, 0, 1, 1, 4'd0,  1, 1, 4'd0);   // wrap 9 -> 0
    addVec(0, 1, 1, 0, 4'd15, 1, 1, 4'd9);   // carry is tick & AtEnd even during load

    resetAll();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_atend", i), 32'(atEndA), 32'(vecs[i].expAtEnd));
      checkOutput($sformatf("vec%0d_carry", i), 32'(carryA), 32'(vecs[i].expCarry));
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d_x", i), 32'(xA), 32'(vecs[i].expX));
    end

    // ---- DIV=3: tick every third enabled cycle; Enable low freezes X and P ----
    expC = '{0, 0, 1, 1, 1, 2, 2};
    reset = 1'b1;
    resetAll();
    enC = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("div3_run%0d", i), 32'(xC), 32'(expC[i]));
    end
    @(negedge clock);
    enC = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("div3_frozen%0d", i), 32'(xC), 32'd2);
    end
    @(negedge clock);
    enC = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("div3_resume_a", 32'(xC), 32'd2);
    @(posedge clock);
    #1;
    checkOutput("div3_resume_b", 32'(xC), 32'd3);

    // ---- Asynchronous reset mid-count (X=6, P=1) ----
    resetAll();
    enC = 1'b1;
    repeat (19) @(posedge clock);
    #1;
    checkOutput("areset_pre_x", 32'(xC), 32'd6);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("areset_now_x", 32'(xC), 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("areset_edge1", 32'(xC), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("areset_edge2", 32'(xC), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("areset_edge3", 32'(xC), 32'd1);

    // ---- SAT=1 down count from 2, then clamp-load of 12 and hold at 9 ----
    expPre  = '{0, 0, 1, 1};
    expPost = '{1, 0, 0, 0};
    resetAll();
    @(negedge clock);
    load = 1'b1; d = 4'd2; up = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("sat_load2", 32'(xD), 32'd2);
    @(negedge clock);
    load = 1'b0; enD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("sat_carry%0d", i), 32'(carryD), 32'(expPre[i]));
      @(posedge clock);
      #1;
      checkOutput($sformatf("sat_x%0d", i), 32'(xD), 32'(expPost[i]));
    end
    @(negedge clock);
    enD = 1'b0; load = 1'b1; d = 4'd12;
    @(posedge clock);
    #1;
    checkOutput("sat_load12", 32'(xD), 32'd9);
    @(negedge clock);
    load = 1'b0; up = 1'b1; enD = 1'b1;
    #1;
    checkOutput("sat_carry_top", 32'(carryD), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("sat_hold_top", 32'(xD), 32'd9);

    // ---- MOD=16: natural 4-bit rollover in both directions ----
    resetAll();
    @(negedge clock);
    up = 1'b0; enE = 1'b1;
    #1;
    checkOutput("mod16_carry_down", 32'(carryE), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("mod16_x_down", 32'(xE), 32'd15);
    @(negedge clock);
    up = 1'b1;
    #1;
    checkOutput("mod16_carry_up", 32'(carryE), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("mod16_x_up", 32'(xE), 32'd0);

    // ---- Two-stage cascade counts 00..99 and wraps to 00 ----
    resetAll();
    @(negedge clock);
    up = 1'b1; enA = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      if (k == 100)
        checkOutput("cascade_carry99", 32'(carryB), 32'd1);
      @(posedge clock);
      #1;
      checkOutput($sformatf("cascade_%0d", k), 32'(xB) * 10 + 32'(xA), 32'(k % 100));
    end
    @(negedge clock);
    enA = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/count_mod_ud.md
COUNT_MOD_UD -- requirements
Module: count_mod_ud

Interface
REQ-001 SHALL have parameter N, default 4: counter width in bits, range 1..16.
REQ-002 SHALL have parameter MOD, default 16: count modulus, range 2..2^N; X spans 0..MOD-1.
REQ-003 SHALL have parameter DIV, default 1: prescale ratio, range 1..256; X advances once per DIV enabled cycles.
REQ-004 SHALL have parameter SAT, default 0: 0 means wrap at terminal, 1 means hold at terminal.
REQ-005 SHALL have port Clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port Enable, input, 1 bit: advances the prescaler when high.
REQ-008 SHALL have port Clear, input, 1 bit: synchronous clear of X and the prescaler.
REQ-009 SHALL have port Load, input, 1 bit: synchronous parallel load of X from D.
REQ-010 SHALL have port D, input, N bits: load value.
REQ-011 SHALL have port Up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-012 SHALL have port X, output, N bits: registered count value.
REQ-013 SHALL have port AtEnd, output, 1 bit: combinational; high when X equals the terminal value for the current Up (MOD-1 if Up=1, 0 if Up=0).
REQ-014 SHALL have port Carry, output, 1 bit: combinational, equal to Tick AND AtEnd; used to cascade into the next stage's Enable.

Function
REQ-015 SHALL hold an internal prescaler P of width ceil(log2(DIV)), or no register when DIV=1.
REQ-016 SHALL define the internal Tick as Enable AND (P == DIV-1); when DIV=1, Tick SHALL equal Enable.
REQ-017 With Enable=1, P SHALL increment each cycle and wrap from DIV-1 to 0; with Enable=0, P SHALL hold.
REQ-018 SHALL apply per-edge priority Clear > Load > Tick count > hold.
REQ-019 When Clear=1, the next X SHALL be 0 and the next P SHALL be 0, regardless of Load, Enable and Up.
REQ-020 When Load=1 and Clear=0, the next X SHALL be D if D < MOD, else MOD-1, and the next P SHALL be 0.
REQ-021 On a Tick with Up=1 and X < MOD-1, the next X SHALL be X+1.
REQ-022 On a Tick with Up=1 and X = MOD-1, the next X SHALL be 0 if SAT=0, else MOD-1.
REQ-023 On a Tick with Up=0 and X > 0, the next X SHALL be X-1.
REQ-024 On a Tick with Up=0 and X = 0, the next X SHALL be MOD-1 if SAT=0, else 0.
REQ-025 With no Clear, Load or Tick, X SHALL hold.
REQ-026 A change of Up SHALL take effect on the next Tick, with no extra latency; AtEnd and Carry SHALL follow Up combinationally.
REQ-027 Carry SHALL assert in SAT=1 mode whenever Tick occurs at the terminal value, including while X is held.
REQ-028 X SHALL never leave the range 0..MOD-1 by any input sequence after reset.
REQ-029 For MOD = 2^N with SAT=0, wrap SHALL match natural N-bit rollover.

Reset
REQ-030 Reset=1 SHALL force X=0 and P=0 immediately, independent of Clk.
REQ-031 While Reset=1, all inputs SHALL be ignored; AtEnd SHALL reflect X=0 and the current Up.
REQ-032 After Reset deasserts, the first Tick SHALL occur DIV enabled cycles later.
REQ-033 Reset asserted mid-count SHALL discard the prescaler phase and the count.

Verification
REQ-034 N=4, MOD=10, DIV=1, SAT=0, Up=1, Enable=1, run from reset -> X steps 0..9, then 0; Carry high only in the cycle X=9.
REQ-035 N=4, MOD=10, DIV=3, Up=1 -> X increments every 3rd enabled cycle; deasserting Enable for 5 cycles freezes both X and P.
REQ-036 SAT=1, MOD=10, Up=0, Load with D=2 -> X=2, 1, 0, 0, 0; Carry high on each Tick at 0. Repeat with D=12 -> X loads 9.
REQ-037 Clear, Load and Tick asserted in the same cycle with X=5 -> X=0 next cycle; Load and Tick together with D=7 -> X=7 and P=0.
REQ-038 Reset pulsed asynchronously between edges while X=6 and P=1 -> X=0 at once; next Tick arrives DIV cycles after release.
REQ-039 Two instances with N=4, MOD=10 cascaded through Carry into the second stage's Enable -> pair counts 00..99 and wraps to 00.
